// File: rtl/rx_majority_sampler.sv
// Majority-vote bit sampler for an oversampled UART receive path.
// Optional macro SAMPLER_NOISE_DET_EN enables the noise_err (non-unanimous vote) detector.
module rx_majority_sampler #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned NSAMP      = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_in,
    input  logic                  dat_samp_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  sampled_valid,
    output logic                  noise_err,
    output logic                  cfg_err
);

    localparam int unsigned CW = PRESCALE_W + 4;
    localparam int unsigned KW = $clog2(NSAMP + 1);

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q;
    logic               rx_s;
    logic [NSAMP-1:0]   votes_q, votes_d;
    logic               bit_d;
    logic               valid_d;

    logic [CW-1:0]      ps_ext;
    logic [CW-1:0]      ec_ext;
    logic [CW-1:0]      center;
    logic [KW-1:0]      n_eff;
    logic [KW-1:0]      ones;
    logic               samp_ok;
    logic               at_start;
    logic               at_decide;

    // Two-flop synchronizer; idles high like the line
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_in};
        end
    end

    assign rx_s = sync_q[1];

    // Window geometry: fall back to a single vote when NSAMP does not fit before the bit end
    always_comb begin
        ps_ext  = CW'(prescale);
        ec_ext  = CW'(edge_cnt);
        center  = ps_ext >> 1;
        n_eff   = ((center + CW'(NSAMP) + CW'(1)) <= ps_ext) ? KW'(NSAMP) : KW'(1);
        cfg_err = (ps_ext < CW'(4));
        samp_ok = dat_samp_en && !cfg_err;
    end

    always_comb begin
        ones = '0;
        for (int unsigned k = 0; k < NSAMP; k++) begin
            if ((KW'(k) < n_eff) && votes_q[k]) begin
                ones = ones + KW'(1);
            end
        end
    end

    assign at_start  = samp_ok && (ec_ext == center);
    assign at_decide = samp_ok && (state_q == S_COLLECT) && (ec_ext == center + CW'(n_eff));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            votes_q       <= '1;
            sampled_bit   <= 1'b1;
            sampled_valid <= 1'b0;
        end else begin
            state_q       <= state_d;
            votes_q       <= votes_d;
            sampled_bit   <= bit_d;
            sampled_valid <= valid_d;
        end
    end

    // A decision needs a window that started at the center after reset/enable
    always_comb begin
        state_d = state_q;
        votes_d = votes_q;
        bit_d   = sampled_bit;
        valid_d = 1'b0;
        if (!dat_samp_en) begin
            state_d = S_IDLE;
            votes_d = '1;
        end else if (cfg_err) begin
            state_d = S_IDLE;
        end else begin
            if (at_start) begin
                state_d = S_COLLECT;
            end
            for (int unsigned k = 0; k < NSAMP; k++) begin
                if ((KW'(k) < n_eff) && (ec_ext == center + CW'(k))) begin
                    votes_d[k] = rx_s;
                end
            end
            if (at_decide) begin
                state_d = S_IDLE;
                bit_d   = (ones > (n_eff >> 1));
                valid_d = 1'b1;
            end
        end
    end

`ifdef SAMPLER_NOISE_DET_EN
    logic noise_d;

    always_comb begin
        noise_d = 1'b0;
        if (at_decide) begin
            noise_d = (ones != '0) && (ones != n_eff);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            noise_err <= 1'b0;
        end else begin
            noise_err <= noise_d;
        end
    end
`else
    assign noise_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_majority_sampler.sv
// Bench for rx_majority_sampler: two instances (NSAMP=3 and NSAMP=5) against a spec-level model.
module tb_rx_majority_sampler;

`ifdef SAMPLER_NOISE_DET_EN
    localparam bit NOISE_ON = 1'b1;
`else
    localparam bit NOISE_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_in = 1'b1;
    logic       en = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [5:0] edge_cnt = 6'd0;

    logic b3, v3, n3, c3;
    logic b5, v5, n5, c5;

    int n_cmp = 0;
    int n_fail = 0;

    rx_majority_sampler #(.PRESCALE_W(6), .NSAMP(3)) u3 (
        .CLK(CLK), .RST(RST), .RX_in(RX_in), .dat_samp_en(en),
        .prescale(prescale), .edge_cnt(edge_cnt),
        .sampled_bit(b3), .sampled_valid(v3), .noise_err(n3), .cfg_err(c3)
    );

    rx_majority_sampler #(.PRESCALE_W(6), .NSAMP(5)) u5 (
        .CLK(CLK), .RST(RST), .RX_in(RX_in), .dat_samp_en(en),
        .prescale(prescale), .edge_cnt(edge_cnt),
        .sampled_bit(b5), .sampled_valid(v5), .noise_err(n5), .cfg_err(c5)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: votes per window offset, decisions only after a full window
    int  ns_of [2] = '{3, 5};
    bit  m_votes [2][8];
    bit  m_bit [2] = '{1'b1, 1'b1};
    bit  m_valid [2];
    bit  m_noise [2];
    bit  m_armed [2];
    bit  m_s0 = 1'b1, m_s1 = 1'b1;
    int  mc, mn, mec, mones;
    bit  mcfg, mrx;

    initial begin
        for (int i = 0; i < 2; i++) for (int k = 0; k < 8; k++) m_votes[i][k] = 1'b1;
    end

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 2; i++) begin
                m_bit[i] = 1'b1; m_valid[i] = 1'b0; m_noise[i] = 1'b0; m_armed[i] = 1'b0;
                for (int k = 0; k < 8; k++) m_votes[i][k] = 1'b1;
            end
            m_s0 = 1'b1;
            m_s1 = 1'b1;
        end else begin
            mrx = m_s1;
            for (int i = 0; i < 2; i++) begin
                mc   = int'(prescale) / 2;
                mn   = (mc + ns_of[i] <= int'(prescale) - 1) ? ns_of[i] : 1;
                mcfg = int'(prescale) < 4;
                mec  = int'(edge_cnt);
                m_valid[i] = 1'b0;
                m_noise[i] = 1'b0;
                if (!en) begin
                    m_armed[i] = 1'b0;
                    for (int k = 0; k < 8; k++) m_votes[i][k] = 1'b1;
                end else if (mcfg) begin
                    m_armed[i] = 1'b0;
                end else if (mec >= mc && mec < mc + mn) begin
                    m_votes[i][mec - mc] = mrx;
                    if (mec == mc) m_armed[i] = 1'b1;
                end else if (mec == mc + mn && m_armed[i]) begin
                    mones = 0;
                    for (int k = 0; k < mn; k++) mones += int'(m_votes[i][k]);
                    m_bit[i]   = (2 * mones > mn);
                    m_valid[i] = 1'b1;
                    m_noise[i] = NOISE_ON && (mones != 0) && (mones != mn);
                    m_armed[i] = 1'b0;
                end
            end
            m_s1 = m_s0;
            m_s0 = RX_in;
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge CLK) begin
        check("bit_n3",   int'(b3), int'(m_bit[0]));
        check("valid_n3", int'(v3), int'(m_valid[0]));
        check("noise_n3", int'(n3), int'(m_noise[0]));
        check("cfg_n3",   int'(c3), int'(prescale < 6'd4));
        check("bit_n5",   int'(b5), int'(m_bit[1]));
        check("valid_n5", int'(v5), int'(m_valid[1]));
        check("noise_n5", int'(n5), int'(m_noise[1]));
        check("cfg_n5",   int'(c5), int'(prescale < 6'd4));
    end

    // Capture of the most recent decision per instance for the literal checks
    int v_cnt [2] = '{0, 0};
    bit v_bit [2];
    bit v_noise [2];
    always @(negedge CLK) begin
        if (v3) begin v_cnt[0]++; v_bit[0] = b3; v_noise[0] = n3; end
        if (v5) begin v_cnt[1]++; v_bit[1] = b5; v_noise[1] = n5; end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // rxs bit e = desired rx_s during edge_cnt e; RX_in is driven two cycles ahead
    task automatic run_bit(input int ps, input logic [63:0] rxs, input int drop_at, input int rst_at);
        prescale = 6'(ps);
        en = 1'b0;
        RX_in = rxs[0];
        tick();
        RX_in = rxs[1];
        tick();
        for (int e = 0; e < ps; e++) begin
            en = (drop_at < 0) || (e < drop_at);
            edge_cnt = 6'(e);
            RX_in = (e + 2 < ps) ? rxs[e + 2] : 1'b1;
            if (e == rst_at) begin
                #1 RST = 1'b0;
                #1;
                check("rst_bit_n3",   int'(b3), 1);
                check("rst_valid_n3", int'(v3), 0);
                check("rst_bit_n5",   int'(b5), 1);
                check("rst_valid_n5", int'(v5), 0);
                #1 RST = 1'b1;
            end
            tick();
        end
        en = 1'b0;
        edge_cnt = 6'd0;
        tick();
    endtask

    int c0, c1;

    initial begin
        #2 RST = 1'b0;
        #10;
        check("reset_bit_n3",   int'(b3), 1);
        check("reset_valid_n3", int'(v3), 0);
        check("reset_noise_n3", int'(n3), 0);
        check("reset_bit_n5",   int'(b5), 1);
        check("reset_valid_n5", int'(v5), 0);
        #1 RST = 1'b1;
        tick();

        // 1,0,1 at edge_cnt 4..6, prescale 8
        c0 = v_cnt[0]; c1 = v_cnt[1];
        run_bit(8, 64'hFFFF_FFFF_FFFF_FFDF, -1, -1);
        check("p8_101_cnt_n3",   v_cnt[0], c0 + 1);
        check("p8_101_bit_n3",   int'(v_bit[0]), 1);
        check("p8_101_noise_n3", int'(v_noise[0]), int'(NOISE_ON));
        check("p8_101_cnt_n5",   v_cnt[1], c1 + 1);
        check("p8_101_bit_n5",   int'(v_bit[1]), 1);
        check("p8_101_noise_n5", int'(v_noise[1]), 0);

        // zeros at edge_cnt 8..12, prescale 16
        c0 = v_cnt[0]; c1 = v_cnt[1];
        run_bit(16, 64'hFFFF_FFFF_FFFF_E0FF, -1, -1);
        check("p16_zero_cnt_n5",   v_cnt[1], c1 + 1);
        check("p16_zero_bit_n5",   int'(v_bit[1]), 0);
        check("p16_zero_noise_n5", int'(v_noise[1]), 0);
        check("p16_zero_cnt_n3",   v_cnt[0], c0 + 1);
        check("p16_zero_bit_n3",   int'(v_bit[0]), 0);

        // prescale 4: single vote at edge_cnt 2
        c0 = v_cnt[0]; c1 = v_cnt[1];
        run_bit(4, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1);
        check("p4_cnt_n3", v_cnt[0], c0 + 1);
        check("p4_bit_n3", int'(v_bit[0]), 1);
        check("p4_cnt_n5", v_cnt[1], c1 + 1);
        check("p4_bit_n5", int'(v_bit[1]), 1);

        // prescale 2: unsupported, no decisions
        c0 = v_cnt[0]; c1 = v_cnt[1];
        run_bit(2, 64'h0, -1, -1);
        check("p2_cfg_n3", int'(c3), 1);
        check("p2_cnt_n3", v_cnt[0], c0);
        check("p2_cnt_n5", v_cnt[1], c1);

        // set sampled_bit to 0, then abort the next bit at edge_cnt 5
        run_bit(8, 64'h0, -1, -1);
        c0 = v_cnt[0]; c1 = v_cnt[1];
        run_bit(8, 64'hFFFF_FFFF_FFFF_FFFF, 5, -1);
        check("abort_cnt_n3", v_cnt[0], c0);
        check("abort_bit_n3", int'(b3), 0);
        check("abort_cnt_n5", v_cnt[1], c1);
        check("abort_bit_n5", int'(b5), 0);

        // reset mid-bit at edge_cnt 5, then a full window decides 0
        c0 = v_cnt[0]; c1 = v_cnt[1];
        run_bit(8, 64'h0, -1, 5);
        check("rst_win_cnt_n3", v_cnt[0], c0);
        check("rst_win_cnt_n5", v_cnt[1], c1);
        run_bit(8, 64'h0, -1, -1);
        check("after_rst_cnt_n3", v_cnt[0], c0 + 1);
        check("after_rst_bit_n3", int'(v_bit[0]), 0);
        check("after_rst_bit_n5", int'(v_bit[1]), 0);

        // votes 1,1,0
        c0 = v_cnt[0];
        run_bit(8, 64'hFFFF_FFFF_FFFF_FFBF, -1, -1);
        check("p8_110_cnt_n3",   v_cnt[0], c0 + 1);
        check("p8_110_bit_n3",   int'(v_bit[0]), 1);
        check("p8_110_noise_n3", int'(v_noise[0]), int'(NOISE_ON));
        check("p8_110_bit_n5",   int'(v_bit[1]), 1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
